cnn_header_reader: RTL and testbench

- Reads back the network configuration header that the loader writes into the shared byte RAM, and presents it as registered configuration fields to the coordinator and the CNN datapath.
- Sits between the RAM read port and the layer sequencer.
- Runs once per `start`, issuing one RAM read per cycle, then holds the fields until the next `start` or reset.
- Header layout (byte addresses, multi-byte fields MSB first):
  - 0: filterSize
  - 1: numLayers (N)
  - 2-3: filterOffset
  - 4-5: denseOffset
  - 6 .. 6+N-1: per-layer filter counts
  - 6+N .. 6+2N-2: per-layer dense counts

---
 rtl/cnn_io_pkg.sv | 38 +++
 rtl/layer_count_rf.sv | 39 +++
 rtl/cnn_header_reader.sv | 210 +++++++++++++++++++++
 tb/tb_cnn_header_reader.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_io_pkg.sv
// Shared definitions for the CNN configuration header path: byte offsets,
// default layer limit, captured-field payload and the reader state encoding.
package cnn_io_pkg;

    localparam int unsigned HDR_FSIZE      = 0;
    localparam int unsigned HDR_NLAYERS    = 1;
    localparam int unsigned HDR_FOFF       = 2;
    localparam int unsigned HDR_DOFF       = 4;
    localparam int unsigned HDR_COUNTS     = 6;

    localparam int unsigned MAX_LAYERS_DEF = 10;
    localparam int unsigned IDX_W          = 4;
    localparam int unsigned CNT_W          = 8;

    // Fixed-position header fields as presented to the coordinator
    typedef struct packed {
        logic [7:0]  fsize;
        logic [7:0]  nlayers;
        logic [15:0] foff;
        logic [15:0] doff;
    } hdr_fields_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_HDR   = 3'd1,
        ST_RD_FILT  = 3'd2,
        ST_RD_DENSE = 3'd3,
        ST_DRAIN    = 3'd4,
        ST_DONE     = 3'd5,
        ST_ERR      = 3'd6
    } hdr_state_e;

    // True for the states that issue one RAM read per cycle
    function automatic logic is_read_state(input hdr_state_e s);
        return (s == ST_RD_HDR) || (s == ST_RD_FILT) || (s == ST_RD_DENSE);
    endfunction

endpackage

// File: rtl/layer_count_rf.sv
// Per-layer count register file: one write port, one combinational read port
// that returns 0 for indices at or beyond the live limit or the array depth.
module layer_count_rf
    import cnn_io_pkg::*;
#(
    parameter int unsigned DEPTH = MAX_LAYERS_DEF
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             i_clr,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [CNT_W-1:0] i_wdata,
    input  logic [IDX_W-1:0] i_raddr,
    input  logic [7:0]       i_limit,
    output logic [CNT_W-1:0] o_rdata_c
);

    logic [CNT_W-1:0] r_mem [DEPTH];
    logic             w_wr_ok;
    logic             w_rd_ok;

    assign w_wr_ok = i_we && (32'(i_waddr) < DEPTH);
    assign w_rd_ok = (8'(i_raddr) < i_limit) && (32'(i_raddr) < DEPTH);

    // Storage: cleared on reset or on a new header read, else written
    always_ff @(posedge clk) begin
        if (!RST || i_clr) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[IDX_W'(i)] <= '0;
            end
        end else if (w_wr_ok) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_c = w_rd_ok ? r_mem[i_raddr] : '0;

endmodule

// File: rtl/cnn_header_reader.sv
// Reads the network configuration header from the shared byte RAM with one
// pipelined read per cycle and holds the captured fields until the next start.
module cnn_header_reader
    import cnn_io_pkg::*;
#(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned MAX_LAYERS = MAX_LAYERS_DEF,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              start,
    output logic [ADDR_W-1:0] ramAddress,
    output logic              ramRead,
    input  logic [DATA_W-1:0] ramDataOut,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [7:0]        filterSize,
    output logic [7:0]        numLayers,
    output logic [15:0]       filterOffset,
    output logic [15:0]       denseOffset,
    input  logic [3:0]        layerIdx,
    output logic [7:0]        filterCount,
    output logic [7:0]        denseCount
);

    hdr_state_e        r_state;
    hdr_state_e        w_state_nxt;
    logic [7:0]        r_idx;
    logic [7:0]        w_idx_nxt;

    logic              r_rd;
    logic              r_busy;
    logic              r_done;
    logic              r_error;
    logic [ADDR_W-1:0] r_addr;
    logic              r_pend;
    logic [7:0]        r_pend_idx;
    hdr_fields_t       r_hdr;

    logic              w_rd_nxt;
    logic              w_busy_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [7:0]        w_byte;
    logic              w_accept;
    logic              w_reject;
    logic              w_filt_last;
    logic              w_dense_last;
    logic              w_filt_we;
    logic              w_dense_we;
    logic [IDX_W-1:0]  w_filt_waddr;
    logic [IDX_W-1:0]  w_dense_waddr;
    logic [7:0]        w_dense_lim;

    assign w_byte       = 8'(ramDataOut);
    assign w_accept     = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                    (r_state == ST_ERR));
    // Byte 1 is on the data bus while byte 2 is being issued; byte 0 is already held
    assign w_reject     = (r_state == ST_RD_HDR) && (r_idx == 8'(HDR_NLAYERS + 1)) &&
                          ((w_byte == 8'd0) || (w_byte > 8'(MAX_LAYERS)) ||
                           (r_hdr.fsize == 8'd0));
    assign w_filt_last  = (r_idx == r_hdr.nlayers + 8'(HDR_COUNTS - 1));
    assign w_dense_last = (r_idx == (r_hdr.nlayers << 1) + 8'(HDR_COUNTS - 2));

    // State register and header byte index of the read issued this cycle
    always_ff @(posedge clk) begin
        if (!RST) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next-state and next read index
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    w_state_nxt = ST_RD_HDR;
                    w_idx_nxt   = '0;
                end
            end
            ST_RD_HDR: begin
                w_idx_nxt = r_idx + 8'd1;
                if (w_reject) begin
                    w_state_nxt = ST_ERR;
                end else if (r_idx == 8'(HDR_COUNTS - 1)) begin
                    w_state_nxt = ST_RD_FILT;
                end
            end
            ST_RD_FILT: begin
                w_idx_nxt = r_idx + 8'd1;
                if (w_filt_last) begin
                    w_state_nxt = (r_hdr.nlayers == 8'd1) ? ST_DRAIN : ST_RD_DENSE;
                end
            end
            ST_RD_DENSE: begin
                w_idx_nxt = r_idx + 8'd1;
                if (w_dense_last) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_state_nxt = ST_DONE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Next values of the registered handshake outputs; address holds when idle
    always_comb begin
        w_rd_nxt   = is_read_state(w_state_nxt);
        w_busy_nxt = w_rd_nxt || (w_state_nxt == ST_DRAIN);
        w_addr_nxt = r_addr;
        if (w_rd_nxt) begin
            w_addr_nxt = ADDR_W'(BASE_ADDR + 32'(w_idx_nxt));
        end
    end

    // Registered outputs and the one-deep outstanding-read tracker
    always_ff @(posedge clk) begin
        if (!RST) begin
            r_rd       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_addr     <= '0;
            r_pend     <= 1'b0;
            r_pend_idx <= '0;
        end else begin
            r_rd       <= w_rd_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= (w_state_nxt == ST_DONE);
            r_error    <= (w_state_nxt == ST_ERR);
            r_addr     <= w_addr_nxt;
            r_pend     <= r_rd && !w_reject;
            r_pend_idx <= r_idx;
        end
    end

    // Capture the fixed header fields one cycle after their read
    always_ff @(posedge clk) begin
        if (!RST) begin
            r_hdr <= '0;
        end else if (w_accept) begin
            r_hdr <= '0;
        end else if (r_pend) begin
            case (r_pend_idx)
                8'(HDR_FSIZE):    r_hdr.fsize      <= w_byte;
                8'(HDR_NLAYERS):  r_hdr.nlayers    <= w_byte;
                8'(HDR_FOFF):     r_hdr.foff[15:8] <= w_byte;
                8'(HDR_FOFF + 1): r_hdr.foff[7:0]  <= w_byte;
                8'(HDR_DOFF):     r_hdr.doff[15:8] <= w_byte;
                8'(HDR_DOFF + 1): r_hdr.doff[7:0]  <= w_byte;
                default: ;
            endcase
        end
    end

    // Route count bytes to the filter or dense file by their header position
    assign w_filt_we     = r_pend && (r_pend_idx >= 8'(HDR_COUNTS)) &&
                           (r_pend_idx < r_hdr.nlayers + 8'(HDR_COUNTS));
    assign w_dense_we    = r_pend && (r_pend_idx >= r_hdr.nlayers + 8'(HDR_COUNTS));
    assign w_filt_waddr  = IDX_W'(r_pend_idx - 8'(HDR_COUNTS));
    assign w_dense_waddr = IDX_W'(r_pend_idx - 8'(HDR_COUNTS) - r_hdr.nlayers);
    assign w_dense_lim   = (r_hdr.nlayers == 8'd0) ? 8'd0 : r_hdr.nlayers - 8'd1;

    layer_count_rf #(.DEPTH(MAX_LAYERS)) u_filt_rf (
        .clk       (clk),
        .RST       (RST),
        .i_clr     (w_accept),
        .i_we      (w_filt_we),
        .i_waddr   (w_filt_waddr),
        .i_wdata   (w_byte),
        .i_raddr   (layerIdx),
        .i_limit   (r_hdr.nlayers),
        .o_rdata_c (filterCount)
    );

    layer_count_rf #(.DEPTH(MAX_LAYERS)) u_dense_rf (
        .clk       (clk),
        .RST       (RST),
        .i_clr     (w_accept),
        .i_we      (w_dense_we),
        .i_waddr   (w_dense_waddr),
        .i_wdata   (w_byte),
        .i_raddr   (layerIdx),
        .i_limit   (w_dense_lim),
        .o_rdata_c (denseCount)
    );

    assign ramAddress   = r_addr;
    assign ramRead      = r_rd;
    assign busy         = r_busy;
    assign done         = r_done;
    assign error        = r_error;
    assign filterSize   = r_hdr.fsize;
    assign numLayers    = r_hdr.nlayers;
    assign filterOffset = r_hdr.foff;
    assign denseOffset  = r_hdr.doff;

endmodule

// File: tb/tb_cnn_header_reader.sv
// Bench for cnn_header_reader: one instance at base 0, one at base 0xFFFC,
// a shared byte RAM with one-cycle read latency, and a header-level model.
module tb_cnn_header_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start;
    logic        use_w;
    logic [3:0]  layer_idx;

    logic [15:0] d0_addr, d1_addr;
    logic        d0_rd, d1_rd;
    logic [7:0]  d0_q, d1_q;
    logic        d0_busy, d1_busy, d0_done, d1_done, d0_err, d1_err;
    logic [7:0]  d0_fs, d1_fs, d0_nl, d1_nl, d0_fc, d1_fc, d0_dc, d1_dc;
    logic [15:0] d0_foff, d1_foff, d0_doff, d1_doff;

    cnn_header_reader #(.BASE_ADDR(0)) u_dut0 (
        .clk(clk), .RST(rst_n), .start(start && !use_w),
        .ramAddress(d0_addr), .ramRead(d0_rd), .ramDataOut(d0_q),
        .busy(d0_busy), .done(d0_done), .error(d0_err),
        .filterSize(d0_fs), .numLayers(d0_nl),
        .filterOffset(d0_foff), .denseOffset(d0_doff),
        .layerIdx(layer_idx), .filterCount(d0_fc), .denseCount(d0_dc)
    );

    cnn_header_reader #(.BASE_ADDR(32'hFFFC)) u_dut1 (
        .clk(clk), .RST(rst_n), .start(start && use_w),
        .ramAddress(d1_addr), .ramRead(d1_rd), .ramDataOut(d1_q),
        .busy(d1_busy), .done(d1_done), .error(d1_err),
        .filterSize(d1_fs), .numLayers(d1_nl),
        .filterOffset(d1_foff), .denseOffset(d1_doff),
        .layerIdx(layer_idx), .filterCount(d1_fc), .denseCount(d1_dc)
    );

    logic [15:0] m_addr, m_foff, m_doff;
    logic        m_rd, m_busy, m_done, m_err;
    logic [7:0]  m_fs, m_nl, m_fc, m_dc;
    assign m_addr = use_w ? d1_addr : d0_addr;
    assign m_rd   = use_w ? d1_rd   : d0_rd;
    assign m_busy = use_w ? d1_busy : d0_busy;
    assign m_done = use_w ? d1_done : d0_done;
    assign m_err  = use_w ? d1_err  : d0_err;
    assign m_fs   = use_w ? d1_fs   : d0_fs;
    assign m_nl   = use_w ? d1_nl   : d0_nl;
    assign m_foff = use_w ? d1_foff : d0_foff;
    assign m_doff = use_w ? d1_doff : d0_doff;
    assign m_fc   = use_w ? d1_fc   : d0_fc;
    assign m_dc   = use_w ? d1_dc   : d0_dc;

    logic [7:0]  mem [65536];
    logic [15:0] rdq [$];
    logic [7:0]  hdr [$];

    always @(posedge clk) begin
        if (d0_rd) d0_q <= mem[d0_addr];
        if (d1_rd) d1_q <= mem[d1_addr];
    end

    always @(posedge clk) begin
        if (m_rd) rdq.push_back(m_addr);
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Header-level model: rules read straight off the header bytes
    function automatic bit mdl_err();
        return (hdr[1] == 8'd0) || (hdr[1] > 8'd10) || (hdr[0] == 8'd0);
    endfunction

    function automatic int mdl_n();
        return int'(hdr[1]);
    endfunction

    function automatic logic [7:0] mdl_fc(input int i);
        if (mdl_err() || i >= mdl_n()) return 8'd0;
        return hdr[6 + i];
    endfunction

    function automatic logic [7:0] mdl_dc(input int i);
        if (mdl_err() || i >= mdl_n() - 1) return 8'd0;
        return hdr[6 + mdl_n() + i];
    endfunction

    task automatic build_hdr(input logic [7:0] fs, input logic [7:0] nl, input logic [15:0] foff,
                             input logic [15:0] doff, input logic [7:0] step, input bit rnd);
        int ncnt;
        int nn;
        hdr.delete();
        hdr.push_back(fs);
        hdr.push_back(nl);
        hdr.push_back(foff[15:8]);
        hdr.push_back(foff[7:0]);
        hdr.push_back(doff[15:8]);
        hdr.push_back(doff[7:0]);
        nn   = int'(nl);
        ncnt = (nn >= 1 && nn <= 10) ? 2 * nn - 1 : 4;
        for (int k = 0; k < ncnt; k++) begin
            if (rnd) hdr.push_back(8'($urandom));
            else     hdr.push_back(8'(int'(step) * ((k < nn) ? k + 1 : k - nn + 1)));
        end
    endtask

    task automatic load(input int base);
        for (int k = 0; k < hdr.size(); k++) mem[16'(base + k)] = hdr[k];
        mem[16'(base + hdr.size())] = 8'hEE;
    endtask

    // One header read from start to done/error, then compare against the model
    task automatic run_and_check(input int base, input int pulse_cyc, input bit exp_err,
                                 input int exp_cyc, input int exp_reads);
        int cyc;
        int bad;
        layer_idx = 4'd0;
        @(negedge clk);
        rdq.delete();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 1;
        chk("busy_c1", m_busy, 1);
        chk("done_c1", m_done, 0);
        chk("error_c1", m_err, 0);
        chk("fsize_cleared_c1", m_fs, 0);
        chk("fcount_cleared_c1", m_fc, 0);
        while (!(m_done || m_err) && cyc < 100) begin
            if (cyc == pulse_cyc) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc++;
        end
        chk("finish_cycle", cyc, exp_cyc);
        chk("error", m_err, exp_err);
        chk("done", m_done, !exp_err);
        chk("busy_end", m_busy, 0);
        chk("ramRead_end", m_rd, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("reads", rdq.size(), exp_reads);
        bad = 0;
        foreach (rdq[k]) if (rdq[k] !== 16'(base + k)) bad++;
        chk("addr_seq", bad, 0);
        chk("filterSize", m_fs, hdr[0]);
        if (!exp_err) begin
            chk("numLayers", m_nl, hdr[1]);
            chk("filterOffset", m_foff, {hdr[2], hdr[3]});
            chk("denseOffset", m_doff, {hdr[4], hdr[5]});
        end else begin
            chk("filterOffset_err", m_foff, 0);
            chk("denseOffset_err", m_doff, 0);
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            layer_idx = 4'(i);
            #2;
            chk($sformatf("filterCount[%0d]", i), m_fc, mdl_fc(i));
            chk($sformatf("denseCount[%0d]", i), m_dc, mdl_dc(i));
        end
    endtask

    typedef struct {
        logic [7:0]  fs;
        logic [7:0]  nl;
        logic [15:0] foff;
        logic [15:0] doff;
        logic [7:0]  step;
        bit          exp_err;
        int          exp_cyc;
        int          exp_reads;
    } vec_t;

    vec_t vt [7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vt[0] = '{8'd5,   8'd3,  16'h0100, 16'h0A2C, 8'd10, 1'b0, 13, 11};
        vt[1] = '{8'd3,   8'd1,  16'h0007, 16'h0009, 8'd4,  1'b0, 9,  7};
        vt[2] = '{8'd7,   8'd0,  16'h1234, 16'h5678, 8'd1,  1'b1, 4,  3};
        vt[3] = '{8'd7,   8'd11, 16'h1234, 16'h5678, 8'd1,  1'b1, 4,  3};
        vt[4] = '{8'd0,   8'd3,  16'h4321, 16'h8765, 8'd5,  1'b1, 4,  3};
        vt[5] = '{8'd9,   8'd10, 16'hBEEF, 16'hCAFE, 8'd2,  1'b0, 27, 25};
        vt[6] = '{8'd200, 8'd2,  16'hFFFF, 16'h0001, 8'd50, 1'b0, 11, 9};

        for (int k = 0; k < 65536; k++) mem[k] = 8'h00;
        rst_n = 1'b0;
        start = 1'b0;
        use_w = 1'b0;
        layer_idx = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_busy", m_busy, 0);
        chk("rst_done", m_done, 0);
        chk("rst_error", m_err, 0);
        chk("rst_ramRead", m_rd, 0);
        chk("rst_ramAddress", m_addr, 0);
        chk("rst_fields", {m_fs, m_nl, m_foff}, 0);
        chk("rst_counts", {m_fc, m_dc}, 0);

        // Table vectors, back to back (each start is taken from DONE or ERR)
        foreach (vt[v]) begin
            build_hdr(vt[v].fs, vt[v].nl, vt[v].foff, vt[v].doff, vt[v].step, 1'b0);
            load(0);
            run_and_check(0, 0, vt[v].exp_err, vt[v].exp_cyc, vt[v].exp_reads);
        end

        // Randomized headers against the model
        for (int r = 0; r < 16; r++) begin
            logic [7:0] fs;
            logic [7:0] nl;
            fs = ($urandom_range(0, 6) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            nl = 8'($urandom_range(0, 12));
            build_hdr(fs, nl, 16'($urandom), 16'($urandom), 8'd0, 1'b1);
            load(0);
            if (mdl_err()) run_and_check(0, 0, 1'b1, 4, 3);
            else           run_and_check(0, 0, 1'b0, 7 + 2 * mdl_n(), 5 + 2 * mdl_n());
        end

        // Reset asserted for one cycle in the middle of a read
        build_hdr(8'd5, 8'd3, 16'h0100, 16'h0A2C, 8'd10, 1'b0);
        load(0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midrst_busy", m_busy, 0);
        chk("midrst_done", m_done, 0);
        chk("midrst_ramRead", m_rd, 0);
        chk("midrst_ramAddress", m_addr, 0);
        chk("midrst_fields", {m_fs, m_nl, m_foff, m_doff}, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_stays_idle", {m_busy, m_done, m_err, m_rd}, 0);
        run_and_check(0, 0, 1'b0, 13, 11);

        // Start during a read is ignored
        run_and_check(0, 4, 1'b0, 13, 11);

        // Restart from DONE with a modified two-layer header
        build_hdr(8'd8, 8'd2, 16'h0203, 16'h0405, 8'd7, 1'b0);
        load(0);
        run_and_check(0, 0, 1'b0, 11, 9);

        // Header straddling the top of the address space
        use_w = 1'b1;
        build_hdr(8'd6, 8'd2, 16'h1111, 16'h2222, 8'd3, 1'b0);
        load(32'hFFFC);
        run_and_check(32'hFFFC, 0, 1'b0, 11, 9);
        use_w = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
